// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response bus between the fetch stage and imem.
// At most one request is outstanding; a response never arrives in the accept cycle.
interface fetch_stage_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rvalid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rvalid,
        output imem_rdata
    );
endinterface

// File: rtl/fetch_stage.sv
// RV32I fetch stage: owns the PC, issues one imem request at a time and
// fills the IF/ID register, honouring decode stalls and branch redirects.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic                 clk,
    input  logic                 rst,
    fetch_stage_if.master        imem,
    input  logic                 stall,
    input  logic                 redirect,
    input  logic [31:0]          redirect_pc,
    output logic                 id_valid,
    output logic [31:0]          id_pc,
    output logic [31:0]          id_pc_plus4,
    output logic [31:0]          id_instr,
    output logic [4:0]           id_opcode,
    output logic                 id_illegal
);

    localparam logic [1:0] ST_FETCH = 2'd0;
    localparam logic [1:0] ST_WAIT  = 2'd1;
    localparam logic [1:0] ST_HOLD  = 2'd2;

    localparam logic [4:0] NOP_OPCODE = NOP_INSTR[6:2];

    logic [1:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] pc_inflight_q, pc_inflight_d;
    logic        drop_q, drop_d;
    logic [31:0] hold_buf_q, hold_buf_d;

    logic        id_valid_q, id_valid_d;
    logic [31:0] id_pc_q, id_pc_d;
    logic [31:0] id_instr_q, id_instr_d;
    logic [4:0]  id_opcode_q, id_opcode_d;

    logic        load;
    logic [31:0] load_instr;
    logic [31:0] redirect_target;

    assign redirect_target = redirect_pc & ~32'd3;

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        pc_inflight_d = pc_inflight_q;
        drop_d        = drop_q;
        hold_buf_d    = hold_buf_q;
        load          = 1'b0;
        load_instr    = hold_buf_q;

        case (state_q)
            ST_FETCH: begin
                if (imem.imem_ready) begin
                    pc_inflight_d = pc_q;
                    state_d       = ST_WAIT;
                    // A request accepted alongside a redirect is already stale.
                    if (redirect) begin
                        drop_d = 1'b1;
                    end else begin
                        pc_d = pc_q + 32'd4;
                    end
                end
            end
            ST_WAIT: begin
                if (imem.imem_rvalid) begin
                    drop_d = 1'b0;
                    if (redirect || drop_q) begin
                        state_d = ST_FETCH;
                    end else if (stall) begin
                        hold_buf_d = imem.imem_rdata;
                        state_d    = ST_HOLD;
                    end else begin
                        load       = 1'b1;
                        load_instr = imem.imem_rdata;
                        state_d    = ST_FETCH;
                    end
                end else if (redirect) begin
                    drop_d = 1'b1;
                end
            end
            ST_HOLD: begin
                if (redirect) begin
                    hold_buf_d = NOP_INSTR;
                    state_d    = ST_FETCH;
                end else if (!stall) begin
                    load       = 1'b1;
                    load_instr = hold_buf_q;
                    state_d    = ST_FETCH;
                end
            end
            default: begin
                state_d = ST_FETCH;
                drop_d  = 1'b0;
            end
        endcase

        if (redirect) begin
            pc_d = redirect_target;
        end
    end

    // IF/ID register: redirect flushes, a load wins over stall, stall holds, else bubble.
    always_comb begin
        id_valid_d  = id_valid_q;
        id_pc_d     = id_pc_q;
        id_instr_d  = id_instr_q;
        id_opcode_d = id_opcode_q;

        if (redirect || (!load && !stall)) begin
            id_valid_d  = 1'b0;
            id_instr_d  = NOP_INSTR;
            id_opcode_d = NOP_OPCODE;
        end else if (load) begin
            id_valid_d  = 1'b1;
            id_pc_d     = pc_inflight_q;
            id_instr_d  = load_instr;
            id_opcode_d = load_instr[6:2];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_FETCH;
            pc_q          <= RESET_PC;
            pc_inflight_q <= RESET_PC;
            drop_q        <= 1'b0;
            hold_buf_q    <= NOP_INSTR;
            id_valid_q    <= 1'b0;
            id_pc_q       <= 32'd0;
            id_instr_q    <= NOP_INSTR;
            id_opcode_q   <= NOP_OPCODE;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            pc_inflight_q <= pc_inflight_d;
            drop_q        <= drop_d;
            hold_buf_q    <= hold_buf_d;
            id_valid_q    <= id_valid_d;
            id_pc_q       <= id_pc_d;
            id_instr_q    <= id_instr_d;
            id_opcode_q   <= id_opcode_d;
        end
    end

    assign imem.imem_req  = (state_q == ST_FETCH) && !rst;
    assign imem.imem_addr = pc_q;

    assign id_valid    = id_valid_q;
    assign id_pc       = id_pc_q;
    assign id_pc_plus4 = id_pc_q + 32'd4;
    assign id_instr    = id_instr_q;
    assign id_opcode   = id_opcode_q;
    assign id_illegal  = id_valid_q && (id_instr_q[1:0] != 2'b11);

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed vector table, hand-written corner sequences,
// then randomized traffic checked against an in-order instruction-stream model.
module tb_fetch_stage;

    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [31:0] id_pc_plus4;
    logic [31:0] id_instr;
    logic [4:0]  id_opcode;
    logic        id_illegal;

    int checks;
    int failures;

    fetch_stage_if bus ();

    fetch_stage #(
        .RESET_PC  (RESET_PC),
        .NOP_INSTR (NOP_INSTR)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .imem        (bus),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .id_valid    (id_valid),
        .id_pc       (id_pc),
        .id_pc_plus4 (id_pc_plus4),
        .id_instr    (id_instr),
        .id_opcode   (id_opcode),
        .id_illegal  (id_illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        ready;
        logic        rvalid;
        logic [31:0] rdata;
        logic        stall;
        logic        redirect;
        logic [31:0] rpc;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_pc;
        logic [31:0] e_instr;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic row(input logic rd, input logic rv, input logic [31:0] rdat,
                       input logic st, input logic rdr, input logic [31:0] rpc,
                       input logic ereq, input logic [31:0] eaddr,
                       input logic ev, input logic [31:0] epc, input logic [31:0] einstr);
        vec_t v;
        v.ready = rd; v.rvalid = rv; v.rdata = rdat; v.stall = st;
        v.redirect = rdr; v.rpc = rpc; v.e_req = ereq; v.e_addr = eaddr;
        v.e_valid = ev; v.e_pc = epc; v.e_instr = einstr;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic rd, input logic rv, input logic [31:0] rdat,
                         input logic st, input logic rdr, input logic [31:0] rpc);
        bus.imem_ready  = rd;
        bus.imem_rvalid = rv;
        bus.imem_rdata  = rdat;
        stall           = st;
        redirect        = rdr;
        redirect_pc     = rpc;
    endtask

    task automatic chk_id(input string tag, input logic ev, input logic [31:0] epc,
                          input logic [31:0] einstr);
        chk({tag, "_valid"},   32'(id_valid), 32'(ev));
        chk({tag, "_pc"},      id_pc, epc);
        chk({tag, "_plus4"},   id_pc_plus4, epc + 32'd4);
        chk({tag, "_instr"},   id_instr, einstr);
        chk({tag, "_opcode"},  32'(id_opcode), 32'(einstr[6:2]));
        chk({tag, "_illegal"}, 32'(id_illegal), 32'(ev && (einstr[1:0] != 2'b11)));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        drive(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req", 32'(bus.imem_req), 32'd0);
        chk_id("rst", 1'b0, 32'd0, NOP_INSTR);
        chk("rst_opcode_const", 32'(id_opcode), 32'h04);
        @(negedge clk);
        rst = 1'b0;
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1234_5677;
    endfunction

    int          outstanding;
    int          countdown;
    logic [31:0] out_addr;
    logic [31:0] exp_pc;
    int          consumed;

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        drive(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);

        // ready, rvalid, rdata, stall, redirect, rpc | req, addr | valid, pc, instr
        row(1'b1,1'b0,32'h0,        1'b0,1'b0,32'h0,   1'b1,32'h000, 1'b0,32'h000,NOP_INSTR);
        row(1'b1,1'b1,32'h00500093, 1'b0,1'b0,32'h0,   1'b0,32'h004, 1'b1,32'h000,32'h00500093);
        row(1'b1,1'b0,32'h0,        1'b0,1'b0,32'h0,   1'b1,32'h004, 1'b0,32'h000,NOP_INSTR);
        row(1'b0,1'b1,32'h00000063, 1'b1,1'b0,32'h0,   1'b0,32'h008, 1'b0,32'h000,NOP_INSTR);
        row(1'b1,1'b0,32'h0,        1'b1,1'b0,32'h0,   1'b0,32'h008, 1'b0,32'h000,NOP_INSTR);
        row(1'b1,1'b0,32'h0,        1'b0,1'b0,32'h0,   1'b0,32'h008, 1'b1,32'h004,32'h00000063);
        row(1'b0,1'b0,32'h0,        1'b0,1'b0,32'h0,   1'b1,32'h008, 1'b0,32'h004,NOP_INSTR);
        row(1'b1,1'b0,32'h0,        1'b0,1'b0,32'h0,   1'b1,32'h008, 1'b0,32'h004,NOP_INSTR);
        row(1'b0,1'b0,32'h0,        1'b0,1'b1,32'h100, 1'b0,32'h00C, 1'b0,32'h004,NOP_INSTR);
        row(1'b0,1'b1,32'hDEADBEEF, 1'b0,1'b0,32'h0,   1'b0,32'h100, 1'b0,32'h004,NOP_INSTR);
        row(1'b1,1'b0,32'h0,        1'b0,1'b0,32'h0,   1'b1,32'h100, 1'b0,32'h004,NOP_INSTR);
        row(1'b0,1'b1,32'h00000000, 1'b0,1'b0,32'h0,   1'b0,32'h104, 1'b1,32'h100,32'h00000000);
        row(1'b1,1'b0,32'h0,        1'b0,1'b1,32'h203, 1'b1,32'h104, 1'b0,32'h100,NOP_INSTR);
        row(1'b0,1'b1,32'hFFFFFFFF, 1'b0,1'b0,32'h0,   1'b0,32'h200, 1'b0,32'h100,NOP_INSTR);
        row(1'b1,1'b0,32'h0,        1'b0,1'b0,32'h0,   1'b1,32'h200, 1'b0,32'h100,NOP_INSTR);
        row(1'b0,1'b1,32'h00A00113, 1'b0,1'b0,32'h0,   1'b0,32'h204, 1'b1,32'h200,32'h00A00113);
        row(1'b1,1'b0,32'h0,        1'b0,1'b0,32'h0,   1'b1,32'h204, 1'b0,32'h200,NOP_INSTR);
        row(1'b0,1'b1,32'h00000033, 1'b1,1'b0,32'h0,   1'b0,32'h208, 1'b0,32'h200,NOP_INSTR);
        row(1'b0,1'b0,32'h0,        1'b1,1'b1,32'h040, 1'b0,32'h208, 1'b0,32'h200,NOP_INSTR);
        row(1'b1,1'b0,32'h0,        1'b0,1'b0,32'h0,   1'b1,32'h040, 1'b0,32'h200,NOP_INSTR);
        row(1'b0,1'b1,32'h00000033, 1'b0,1'b0,32'h0,   1'b0,32'h044, 1'b1,32'h040,32'h00000033);
        row(1'b1,1'b0,32'h0,        1'b1,1'b0,32'h0,   1'b1,32'h044, 1'b1,32'h040,32'h00000033);
        row(1'b0,1'b1,32'h00000013, 1'b0,1'b0,32'h0,   1'b0,32'h048, 1'b1,32'h044,32'h00000013);

        do_reset();

        foreach (vecs[i]) begin
            if (i != 0) @(negedge clk);
            drive(vecs[i].ready, vecs[i].rvalid, vecs[i].rdata,
                  vecs[i].stall, vecs[i].redirect, vecs[i].rpc);
            #1;
            chk($sformatf("v%0d_req", i),  32'(bus.imem_req), 32'(vecs[i].e_req));
            chk($sformatf("v%0d_addr", i), bus.imem_addr, vecs[i].e_addr);
            @(posedge clk);
            #1;
            chk_id($sformatf("v%0d", i), vecs[i].e_valid, vecs[i].e_pc, vecs[i].e_instr);
        end

        // PC wrap: fetch at 0xFFFFFFFC, next address is 0.
        @(negedge clk);
        drive(1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 32'hFFFF_FFFF);
        @(negedge clk);
        drive(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
        #1;
        chk("wrap_fetch_addr", bus.imem_addr, 32'hFFFF_FFFC);
        @(negedge clk);
        drive(1'b0, 1'b1, 32'h0000_0013, 1'b0, 1'b0, 32'd0);
        #1;
        chk("wrap_next_addr", bus.imem_addr, 32'h0000_0000);
        @(posedge clk);
        #1;
        chk_id("wrap", 1'b1, 32'hFFFF_FFFC, 32'h0000_0013);

        // Reset mid-WAIT, then a late response that must be ignored.
        @(negedge clk);
        drive(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        drive(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
        #1;
        chk("midrst_req", 32'(bus.imem_req), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        drive(1'b0, 1'b1, 32'h0050_0093, 1'b0, 1'b0, 32'd0);
        #1;
        chk("midrst_req_after", 32'(bus.imem_req), 32'd1);
        chk("midrst_addr", bus.imem_addr, RESET_PC);
        @(posedge clk);
        #1;
        chk("midrst_late_valid", 32'(id_valid), 32'd0);

        // Randomized traffic: decode must see the exact in-order stream,
        // restarting at each redirect target.
        do_reset();
        outstanding = 0;
        countdown   = 0;
        out_addr    = 32'd0;
        exp_pc      = RESET_PC;
        consumed    = 0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            if (cyc != 0) @(negedge clk);
            bus.imem_rvalid = 1'b0;
            bus.imem_rdata  = $urandom;
            if (outstanding != 0) begin
                if (countdown == 0) begin
                    bus.imem_rvalid = 1'b1;
                    bus.imem_rdata  = mem_word(out_addr);
                    outstanding     = 0;
                end else begin
                    countdown--;
                end
            end
            bus.imem_ready = ($urandom_range(0, 3) != 0);
            stall          = ($urandom_range(0, 3) == 0);
            redirect       = ($urandom_range(0, 19) == 0);
            redirect_pc    = $urandom;
            #1;
            if (bus.imem_req) begin
                chk("rnd_single_outstanding", 32'(outstanding), 32'd0);
                chk("rnd_addr_align", 32'(bus.imem_addr[1:0]), 32'd0);
                if (bus.imem_ready) begin
                    outstanding = 1;
                    out_addr    = bus.imem_addr;
                    countdown   = int'($urandom_range(0, 3));
                end
            end
            if (id_valid && !stall && !redirect) begin
                chk_id("rnd", 1'b1, exp_pc, mem_word(exp_pc));
                exp_pc = exp_pc + 32'd4;
                consumed++;
            end else if (!id_valid) begin
                chk("rnd_bubble_instr", id_instr, NOP_INSTR);
                chk("rnd_bubble_illegal", 32'(id_illegal), 32'd0);
            end
            if (redirect) exp_pc = redirect_pc & ~32'd3;
        end
        chk("rnd_progress", 32'(consumed >= 100), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
